order_uart_rx: RTL and testbench

- Inbound host link for the order matcher: receives 8N1 UART bytes on `rx` and decodes each byte into one order.
- Drives the matcher's `submit`/`buy_sell`/`price`/`quantity` inputs, giving the return path opposite the matcher's `tx` output.
- Holds one decoded order until the matcher accepts it via `order_ready`; reports framing errors, malformed orders and overflow.

---
 rtl/order_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_order_uart_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_uart_rx.sv
// order_uart_rx
//   Inbound host link for the order matcher. Receives 8N1 UART bytes on rx
//   and decodes each byte into one order. A decoded order is held in a single
//   slot, with submit high, until the matcher accepts it with order_ready.
//
//   Byte layout: [7] buy_sell, [6:4] price, [3] reserved (must be 0),
//                [2:0] quantity (must be nonzero).
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        synchronous, active-high reset
//   rx           asynchronous UART serial input, idle high
//   order_ready  matcher can take an order this cycle
//   submit       order valid, held until accepted
//   buy_sell     1 = buy, 0 = sell (valid while submit=1)
//   price        order price (valid while submit=1)
//   quantity     order quantity (valid while submit=1)
//   frame_err    1-cycle pulse: stop bit sampled low
//   reject       1-cycle pulse: byte received but not a legal order
//   overflow     1-cycle pulse: legal order dropped because the slot was full
module order_uart_rx #(
  parameter int CLKS_PER_BIT = 868  // must be >= 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       order_ready,
  output logic       submit,
  output logic       buy_sell,
  output logic [2:0] price,
  output logic [2:0] quantity,
  output logic       frame_err,
  output logic       reject,
  output logic       overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick, tick_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          byte_done, byte_done_next;
  logic          stop_bad, stop_bad_next;
  logic          rx_meta, rx_s;
  logic          legal;
  logic          load;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      state     <= state_next;
      tick      <= tick_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      byte_done <= byte_done_next;
      stop_bad  <= stop_bad_next;
    end
  end

  // The START state waits half a bit so that every later sample, taken a
  // full bit apart, lands near the middle of its bit. byte_done/stop_bad are
  // one-cycle flags raised on the stop-bit sample edge; the shift register
  // is not touched again until the next DATA phase, so it is still valid
  // while the byte is decoded in the following cycle.
  always_comb begin
    state_next     = state;
    tick_next      = tick + TW'(1);
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    byte_done_next = 1'b0;
    stop_bad_next  = 1'b0;
    case (state)
      IDLE: begin
        tick_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (tick == HALF_LAST) begin
          tick_next    = '0;
          bit_cnt_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick == FULL_LAST) begin
          tick_next    = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (tick == FULL_LAST) begin
          tick_next = '0;
          if (rx_s) begin
            byte_done_next = 1'b1;
            state_next     = IDLE;
          end else begin
            stop_bad_next = 1'b1;
            state_next    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must produce only the one frame_err
        // already flagged, so wait for the line to return high.
        tick_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        tick_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // A new order may load when the slot is empty or is being emptied by a
  // transfer on this same edge.
  always_comb begin
    legal = !shift[3] && (shift[2:0] != 3'd0);
    load  = byte_done && legal && (!submit || order_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      submit    <= 1'b0;
      buy_sell  <= 1'b0;
      price     <= '0;
      quantity  <= '0;
      frame_err <= 1'b0;
      reject    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      submit    <= load || (submit && !order_ready);
      frame_err <= stop_bad;
      reject    <= byte_done && !legal;
      overflow  <= byte_done && legal && submit && !order_ready;
      if (load) begin
        buy_sell <= shift[7];
        price    <= shift[6:4];
        quantity <= shift[2:0];
      end
    end
  end

endmodule

// File: tb/tb_order_uart_rx.sv
// tb_order_uart_rx
//   Self-checking bench for order_uart_rx with CLKS_PER_BIT=16. Frames are
//   driven bit by bit on rx; every expected result event (submit load,
//   reject, overflow, frame_err) is queued when its frame is driven and is
//   popped and compared by a monitor when the DUT produces it.
module tb_order_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       order_ready;
  logic       submit;
  logic       buy_sell;
  logic [2:0] price;
  logic [2:0] quantity;
  logic       frame_err;
  logic       reject;
  logic       overflow;

  always #5 clk = ~clk;

  order_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .order_ready (order_ready),
    .submit      (submit),
    .buy_sell    (buy_sell),
    .price       (price),
    .quantity    (quantity),
    .frame_err   (frame_err),
    .reject      (reject),
    .overflow    (overflow)
  );

  typedef enum logic [1:0] {EV_SUBMIT, EV_REJECT, EV_OVERFLOW, EV_FERR} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic       bs;
    logic [2:0] price;
    logic [2:0] qty;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_level;
    ev_t        exp;
  } vec_t;

  ev_t         exp_q[$];
  int unsigned rise_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        prev_submit = 1'b0;
  logic        prev_ready = 1'b0;

  function automatic ev_t mk_ev(ev_kind_t kind, logic bs, logic [2:0] p, logic [2:0] q);
    ev_t e;
    e.kind  = kind;
    e.bs    = bs;
    e.price = p;
    e.qty   = q;
    return e;
  endfunction

  function automatic vec_t mk_vec(logic [7:0] data, logic stop_level, ev_t e);
    vec_t v;
    v.data       = data;
    v.stop_level = stop_level;
    v.exp        = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare one DUT event against the head of the scoreboard.
  task automatic observe(input ev_kind_t kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
               int'(kind), cyc);
      return;
    end
    e = exp_q.pop_front();
    if (kind != e.kind) begin
      errors++;
      $display("[TB] FAIL event_kind: got %0d, expected %0d at cycle %0d",
               int'(kind), int'(e.kind), cyc);
    end else if (kind != EV_FERR &&
                 (buy_sell != e.bs || price != e.price || quantity != e.qty)) begin
      errors++;
      $display("[TB] FAIL event_fields: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
               buy_sell, price, quantity, e.bs, e.price, e.qty);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples on the falling edge; inputs change just after the rising
  // edge, so the values seen here are the ones the DUT sees next edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_submit && prev_ready) checkOutput("submit_drop_after_transfer", int'(submit), 0);
      if (submit && !prev_submit) begin
        rise_cyc.push_back(cyc);
        observe(EV_SUBMIT);
      end
      if (reject)    observe(EV_REJECT);
      if (overflow)  observe(EV_OVERFLOW);
      if (frame_err) observe(EV_FERR);
    end
    prev_submit = submit;
    prev_ready  = order_ready;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: start bit, 8 data bits LSB first, stop bit at stop_level.
  // rx is left at stop_level afterwards.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_level);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_cycles(CPB);
    end
    rx = stop_level;
    wait_cycles(CPB);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) wait_cycles(1);
    checkOutput("pending_events", exp_q.size(), 0);
  endtask

  task automatic check_fields(input string tag, input int s, input int bs, input int p, input int q);
    checkOutput({tag, "_submit"},   int'(submit),   s);
    checkOutput({tag, "_buy_sell"}, int'(buy_sell), bs);
    checkOutput({tag, "_price"},    int'(price),    p);
    checkOutput({tag, "_quantity"}, int'(quantity), q);
  endtask

  function automatic int all_outputs();
    return int'({submit, buy_sell, price, quantity, frame_err, reject, overflow});
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[5];
    int unsigned t0;

    vecs[0] = mk_vec(8'hD2, 1'b1, mk_ev(EV_SUBMIT, 1'b1, 3'd5, 3'd2));
    vecs[1] = mk_vec(8'h42, 1'b1, mk_ev(EV_SUBMIT, 1'b0, 3'd4, 3'd2));
    vecs[2] = mk_vec(8'h63, 1'b1, mk_ev(EV_SUBMIT, 1'b0, 3'd6, 3'd3));
    vecs[3] = mk_vec(8'h4A, 1'b1, mk_ev(EV_REJECT, 1'b0, 3'd6, 3'd3));
    vecs[4] = mk_vec(8'h40, 1'b1, mk_ev(EV_REJECT, 1'b0, 3'd6, 3'd3));

    reset       = 1'b1;
    rx          = 1'b1;
    order_ready = 1'b1;
    wait_cycles(5);
    checkOutput("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    wait_cycles(5);

    // Valid orders back-to-back, then two illegal bytes.
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp);
      applyStimulus(vecs[i].data, vecs[i].stop_level);
    end
    drain();
    checkOutput("submit_count", rise_cyc.size(), 3);
    if (rise_cyc.size() >= 3) begin
      checkOutput("first_latency", int'(rise_cyc[0] - t0), 156);
      checkOutput("gap_1_2", int'(rise_cyc[1] - rise_cyc[0]), 160);
      checkOutput("gap_2_3", int'(rise_cyc[2] - rise_cyc[1]), 160);
    end
    check_fields("after_reject", 0, 0, 6, 3);

    // Stop bit low followed by a break; one frame_err, then normal decode.
    exp_q.push_back(mk_ev(EV_FERR, 1'b0, 3'd0, 3'd0));
    applyStimulus(8'hD2, 1'b0);
    wait_cycles(40);
    rx = 1'b1;
    drain();
    wait_cycles(20);
    exp_q.push_back(mk_ev(EV_SUBMIT, 1'b0, 3'd4, 3'd2));
    applyStimulus(8'h42, 1'b1);
    drain();
    check_fields("after_break", 0, 0, 4, 2);

    // Short glitch is a false start; the following frame still decodes.
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(30);
    exp_q.push_back(mk_ev(EV_SUBMIT, 1'b1, 3'd5, 3'd2));
    applyStimulus(8'hD2, 1'b1);
    drain();
    check_fields("after_glitch", 0, 1, 5, 2);

    // Matcher stalled: order held, second order overflows.
    order_ready = 1'b0;
    wait_cycles(2);
    exp_q.push_back(mk_ev(EV_SUBMIT, 1'b1, 3'd5, 3'd2));
    applyStimulus(8'hD2, 1'b1);
    wait_cycles(2);
    check_fields("held", 1, 1, 5, 2);
    exp_q.push_back(mk_ev(EV_OVERFLOW, 1'b1, 3'd5, 3'd2));
    applyStimulus(8'h63, 1'b1);
    drain();
    wait_cycles(2);
    check_fields("after_overflow", 1, 1, 5, 2);
    order_ready = 1'b1;
    wait_cycles(1);
    order_ready = 1'b0;
    wait_cycles(1);
    checkOutput("submit_after_accept", int'(submit), 0);
    wait_cycles(3);
    check_fields("accepted_hold", 0, 1, 5, 2);

    // Reset in the middle of a frame abandons it silently.
    order_ready = 1'b1;
    rx = 1'b0;
    wait_cycles(60);
    reset = 1'b1;
    rx    = 1'b1;
    wait_cycles(3);
    checkOutput("midframe_reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    wait_cycles(400);
    checkOutput("post_reset_outputs", all_outputs(), 0);
    checkOutput("post_reset_pending", exp_q.size(), 0);

    exp_q.push_back(mk_ev(EV_SUBMIT, 1'b0, 3'd6, 3'd3));
    applyStimulus(8'h63, 1'b1);
    drain();
    check_fields("after_reset_frame", 0, 0, 6, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
